nand2_filt_bank: RTL and testbench

//  Parametrised successor to the single 2-input NAND brick.

---
 rtl/nand2_filt_bank.sv | 115 +++++++++++
 tb/tb_nand2_filt_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nand2_filt_bank.sv
// ----------------------------------------------------------------------------
// nand2_filt_bank
//
// Purpose:
//   A bank of NCH independent NIN-input NAND (MODE=0) or AND (MODE=1) gates.
//   Each gate output passes through a persistence filter. A channel output
//   changes only after the new raw gate value has been sampled on DEPTH
//   consecutive enabled clock edges. Any shorter glitch is absorbed and its
//   counter falls back to zero. The outputs are registered and glitch-free.
//
// Ports:
//   CELCLK   in   1        clock, rising edge
//   CELRSTN  in   1        asynchronous active-low reset
//   CELV     in   1        supply pin (no logic function)
//   CELG     in   1        ground pin (no logic function)
//   SUB      in   1        substrate pin (no logic function)
//   en       in   1        filter enable; 0 freezes counters and outputs
//   i        in   NCH*NIN  gate inputs; channel c uses i[c*NIN +: NIN]
//   o        out  NCH      filtered, registered gate outputs
//   chg      out  NCH      one-cycle pulse in the cycle o[c] toggles
//   chg_any  out  1        registered OR of the chg terms
// ----------------------------------------------------------------------------
module nand2_filt_bank #(
    parameter int NCH     = 4,
    parameter int NIN     = 2,
    parameter int DEPTH   = 3,
    parameter int MODE    = 0,
    parameter bit RST_VAL = 1'b1
) (
    input  logic               CELCLK,
    input  logic               CELRSTN,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    input  logic               en,
    input  logic [NCH*NIN-1:0] i,
    output logic [NCH-1:0]     o,
    output logic [NCH-1:0]     chg,
    output logic               chg_any
);

    // Counter sized to hold 0..DEPTH. It only ever reaches DEPTH-1, because
    // the output commits on that count instead of incrementing further.
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [NCH-1:0]         raw;
    logic [NCH-1:0]         o_q,   o_d;
    logic [NCH-1:0]         chg_q, chg_d;
    logic                   chg_any_q, chg_any_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;

    // Power pins exist only for brick compatibility and are deliberately ignored.
    logic unused_pwr;
    assign unused_pwr = CELV ^ CELG ^ SUB;

    // Raw gate value per channel. MODE selects AND or NAND for the whole bank.
    always_comb begin
        raw = '0;
        for (int c = 0; c < NCH; c++) begin
            if (MODE != 0) begin
                raw[c] = &i[c*NIN +: NIN];
            end else begin
                raw[c] = ~&i[c*NIN +: NIN];
            end
        end
    end

    // Persistence filter next state.
    // A match clears the counter. A mismatch either advances the counter or,
    // on its DEPTH-th consecutive enabled sample, commits the new value.
    // With en low, every output and counter holds. chg always falls back to
    // zero so that a pulse never stretches across a frozen cycle.
    always_comb begin
        o_d   = o_q;
        cnt_d = cnt_q;
        chg_d = '0;
        if (en) begin
            for (int c = 0; c < NCH; c++) begin
                if (raw[c] == o_q[c]) begin
                    cnt_d[c] = '0;
                end else if (cnt_q[c] == CNT_MAX) begin
                    o_d[c]   = raw[c];
                    cnt_d[c] = '0;
                    chg_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                end
            end
        end
        chg_any_d = |chg_d;
    end

    // State registers.
    // Reset discards all partial counts and returns the outputs to RST_VAL at once.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            o_q       <= {NCH{RST_VAL}};
            cnt_q     <= '0;
            chg_q     <= '0;
            chg_any_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            chg_any_q <= chg_any_d;
        end
    end

    assign o       = o_q;
    assign chg     = chg_q;
    assign chg_any = chg_any_q;

endmodule

// File: tb/tb_nand2_filt_bank.sv
// ----------------------------------------------------------------------------
// tb_nand2_filt_bank
//
// Testbench for nand2_filt_bank in its default configuration:
// NCH=4, NIN=2, DEPTH=3, MODE=NAND, RST_VAL=1.
//
// Inputs are driven 1 time unit after each falling edge. After each rising
// edge, the outputs are checked on the next falling edge. The expected
// {o, chg, chg_any} for each drive step is worked out by hand and queued
// when the step is issued. A separate monitor pops and compares one queued
// entry on every falling edge.
// ----------------------------------------------------------------------------
module tb_nand2_filt_bank;

    logic       CELCLK;
    logic       CELRSTN;
    logic       CELV;
    logic       CELG;
    logic       SUB;
    logic       en;
    logic [7:0] i;
    logic [3:0] o;
    logic [3:0] chg;
    logic       chg_any;

    int         checkCount;
    int         failCount;
    int         stepIdx;
    logic [8:0] expQ[$];
    int         idxQ[$];

    nand2_filt_bank #(
        .NCH     (4),
        .NIN     (2),
        .DEPTH   (3),
        .MODE    (0),
        .RST_VAL (1'b1)
    ) dut (
        .CELCLK  (CELCLK),
        .CELRSTN (CELRSTN),
        .CELV    (CELV),
        .CELG    (CELG),
        .SUB     (SUB),
        .en      (en),
        .i       (i),
        .o       (o),
        .chg     (chg),
        .chg_any (chg_any)
    );

    // Free-running clock, period 10. Rising edges fall at 5, 15, 25, ...
    initial begin
        CELCLK = 1'b0;
        forever #5 CELCLK = ~CELCLK;
    end

    // Drives one step and queues the outputs expected after the next rising
    // edge. With rpulse set, reset is pulsed low and released well before
    // that edge, so only an asynchronous reset can have any effect.
    task automatic applyStimulus(input bit rstn, input bit rpulse, input bit enV,
                                 input logic [7:0] iv, input logic [3:0] eo,
                                 input logic [3:0] echg, input bit eany);
        @(negedge CELCLK);
        #1;
        en = enV;
        i  = iv;
        expQ.push_back({eo, echg, eany});
        idxQ.push_back(stepIdx);
        stepIdx++;
        if (rpulse) begin
            CELRSTN = 1'b0;
            #2;
            CELRSTN = 1'b1;
        end else begin
            CELRSTN = rstn;
        end
    endtask

    // Compares the DUT outputs with one queued expectation.
    task automatic checkOutput(input logic [8:0] expv, input int idx);
        checkCount++;
        if ({o, chg, chg_any} !== expv) begin
            failCount++;
            $display("[TB] FAIL step%0d: got o=%h chg=%h any=%b, want o=%h chg=%h any=%b",
                     idx, o, chg, chg_any, expv[8:5], expv[4:1], expv[0]);
        end
    endtask

    // Monitor: the outputs are presented every cycle, so one queued
    // expectation is consumed on each falling edge.
    initial begin
        forever begin
            @(negedge CELCLK);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front(), idxQ.pop_front());
            end
        end
    end

    initial begin
        checkCount = 0;
        failCount  = 0;
        stepIdx    = 0;
        CELRSTN    = 1'b0;
        CELV       = 1'b1;
        CELG       = 1'b0;
        SUB        = 1'b0;
        en         = 1'b1;
        i          = 8'hFF;

        // Reset held with all inputs high: the outputs stay at RST_VAL.
        applyStimulus(0, 0, 1, 8'hFF, 4'hF, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'hFF, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h0, 0);

        // Persistence on ch0: o[0] falls on the 3rd edge, then rises back.
        applyStimulus(1, 0, 1, 8'h03, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h03, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h03, 4'hE, 4'h1, 1);
        applyStimulus(1, 0, 1, 8'h03, 4'hE, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hE, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hE, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h1, 1);

        // Glitch reject on ch1: two-edge mismatches never reach o.
        // The counter must have returned to 0 between the two runs.
        applyStimulus(1, 0, 1, 8'h0C, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h0C, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h0C, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h0C, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h0, 0);

        // Enable freeze on ch2: two counted edges, then five frozen edges
        // (the inputs change while frozen). The first enabled edge commits.
        applyStimulus(1, 0, 1, 8'h30, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h30, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 0, 8'h30, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 0, 8'h00, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 0, 8'hFF, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 0, 8'h30, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 0, 8'h30, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h30, 4'hB, 4'h4, 1);
        applyStimulus(1, 0, 0, 8'h30, 4'hB, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hB, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hB, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h4, 1);

        // Simultaneous toggles on all four channels, down and back up.
        applyStimulus(1, 0, 1, 8'hFF, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hFF, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hFF, 4'h0, 4'hF, 1);
        applyStimulus(1, 0, 1, 8'hFF, 4'h0, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'hF, 1);

        // Reset mid-count on ch3: the partial count is discarded, so a
        // fresh three-edge run is needed before o[3] falls.
        applyStimulus(1, 0, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 1, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hC0, 4'h7, 4'h8, 1);

        // Reset pulse with o[3] low restores RST_VAL immediately.
        applyStimulus(1, 1, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hC0, 4'hF, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'hC0, 4'h7, 4'h8, 1);
        applyStimulus(1, 0, 1, 8'h00, 4'h7, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'h7, 4'h0, 0);
        applyStimulus(1, 0, 1, 8'h00, 4'hF, 4'h8, 1);

        // Reset asserted again with all inputs high.
        applyStimulus(0, 0, 1, 8'hFF, 4'hF, 4'h0, 0);

        // Let the monitor drain the queue, with a bounded wait.
        for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
            @(negedge CELCLK);
        end
        #2;
        if (expQ.size() > 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
